// File: rtl/ifm_in_fsm.sv
// Receive-side framer for the s2mm path: forwards MAC RX beats to the data FIFO and
// emits one status word per frame carrying byte count, flags and a ones'-complement checksum.
module ifm_in_fsm #(
  parameter int unsigned C_CSUM_START = 14,
  parameter int unsigned C_MIN_LEN    = 60,
  parameter int unsigned C_MAX_LEN    = 1518
) (
  input  logic        rx_clk,
  input  logic        s2mm_resetn,
  input  logic [72:0] rx_fifo_rdata,
  input  logic        rx_fifo_empty,
  output logic        rx_fifo_rden,
  output logic [72:0] data_fifo_wdata,
  output logic        data_fifo_wren,
  input  logic        data_fifo_afull,
  output logic [33:0] sts_fifo_wdata,
  output logic        sts_fifo_wren,
  input  logic        sts_fifo_afull,
  output logic [3:0]  ifm_in_fsm_dbg
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DATA = 3'd1,
    S_FOLD = 3'd2,
    S_STS  = 3'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] bcnt;
  logic [31:0] acc;

  logic [3:0]  popcnt;
  logic [7:0]  masked [8];
  logic [31:0] acc_beat;
  logic [16:0] bcnt_sum;
  logic [15:0] bcnt_nxt;
  logic [16:0] fold_sum;
  logic [15:0] fold_res;

  assign ifm_in_fsm_dbg = {1'b0, state};

  always_comb begin
    state_nxt    = state;
    rx_fifo_rden = 1'b0;
    unique case (state)
      S_IDLE: if (!rx_fifo_empty && !sts_fifo_afull) state_nxt = S_DATA;
      S_DATA: begin
        rx_fifo_rden = !rx_fifo_empty && !data_fifo_afull;
        if (rx_fifo_rden && rx_fifo_rdata[72]) state_nxt = S_FOLD;
      end
      S_FOLD: state_nxt = S_STS;
      S_STS:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bytes before the checksum start offset or with keep low are zeroed before word pairing.
  always_comb begin
    popcnt   = '0;
    acc_beat = '0;
    masked   = '{default: '0};
    for (int unsigned j = 0; j < 8; j++) begin
      popcnt = popcnt + {3'b000, rx_fifo_rdata[64+j]};
      if (rx_fifo_rdata[64+j] && ((32'(bcnt) + j) >= C_CSUM_START))
        masked[j] = rx_fifo_rdata[8*j +: 8];
    end
    for (int unsigned k = 0; k < 4; k++)
      acc_beat = acc_beat + {16'h0000, masked[2*k], masked[2*k+1]};
  end

  always_comb begin
    bcnt_sum = {1'b0, bcnt} + {13'b0, popcnt};
    bcnt_nxt = bcnt_sum[16] ? 16'hFFFF : bcnt_sum[15:0];
    fold_sum = {1'b0, acc[15:0]} + {1'b0, acc[31:16]};
    fold_res = fold_sum[15:0] + {15'b0, fold_sum[16]};
  end

  always_ff @(posedge rx_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) state <= S_IDLE;
    else              state <= state_nxt;
  end

  always_ff @(posedge rx_clk or negedge s2mm_resetn) begin
    if (!s2mm_resetn) begin
      data_fifo_wdata <= '0;
      data_fifo_wren  <= 1'b0;
      sts_fifo_wdata  <= '0;
      sts_fifo_wren   <= 1'b0;
      bcnt            <= '0;
      acc             <= '0;
    end else begin
      data_fifo_wdata <= rx_fifo_rdata;
      data_fifo_wren  <= rx_fifo_rden;
      // Status word is built during S_FOLD so the push lands exactly while in S_STS.
      sts_fifo_wren   <= (state == S_FOLD);
      unique case (state)
        S_IDLE: begin
          bcnt <= '0;
          acc  <= '0;
        end
        S_DATA: if (rx_fifo_rden) begin
          bcnt <= bcnt_nxt;
          acc  <= acc + acc_beat;
        end
        S_FOLD: sts_fifo_wdata <= {(32'(bcnt) > C_MAX_LEN), (32'(bcnt) < C_MIN_LEN), bcnt, fold_res};
        default: ;
      endcase
    end
  end

endmodule
